multicycle_control: RTL and testbench

Multi-cycle main controller for the RV64 subset datapath (R-type, ld, sd, beq). It is a Moore-style FSM that sequences a shared-memory datapath through fetch, decode, execute, memory and writeback steps, and drives the mux selects and write strobes for that datapath. A memory-ready handshake lets it stall on slow memory. It also flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_control_pkg.sv | 45 ++++
 rtl/multicycle_control_retire_counter.sv | 26 ++
 rtl/multicycle_control.sv | 159 +++++++++++++++
 tb/tb_multicycle_control.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle RV64-subset controller: decoded
// opcodes, FSM state encoding and the ALU operand/operation select codes
// (the ALU control block uses the same encodings).
package multicycle_control_pkg;

    // Decoded opcodes (instr[6:0])
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] LD     = 7'b0000011;
    localparam logic [6:0] SD     = 7'b0100011;
    localparam logic [6:0] BEQ    = 7'b1100011;

    // Controller states, 4-bit encoding
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEM_ADDR = 4'd2;
    localparam state_t S_MEM_RD   = 4'd3;
    localparam state_t S_MEM_WB   = 4'd4;
    localparam state_t S_MEM_WR   = 4'd5;
    localparam state_t S_EXEC_R   = 4'd6;
    localparam state_t S_R_WB     = 4'd7;
    localparam state_t S_BRANCH   = 4'd8;
    localparam state_t S_ILLEGAL  = 4'd9;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // True for the two opcodes that go through the address-compute step
    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == LD) || (op == SD);
    endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: CNT_W-bit enable counter, wraps modulo
// 2^CNT_W, cleared by the asynchronous active-high reset.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count one per enabled cycle; natural overflow provides the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            // NOTE: state registers use <= so every flop samples the pre-edge values.
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller for the RV64 subset datapath (R-type, ld, sd,
// beq). Moore FSM with mem_ready-qualified strobes in the memory wait
// states; flags illegal opcodes and counts retired instructions.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retired_count
);

    state_t r_state;
    state_t w_next_state;

    // The branch decision (zero AND PCWriteCond) is made in the datapath
    logic w_unused_zero;
    assign w_unused_zero = zero;

    // State register; reset aborts whatever instruction is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; mem_ready only matters in FETCH, MEM_RD and MEM_WR
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                if (is_mem_op(opcode))    w_next_state = S_MEM_ADDR;
                else if (opcode == R_TYPE) w_next_state = S_EXEC_R;
                else if (opcode == BEQ)    w_next_state = S_BRANCH;
                else                       w_next_state = S_ILLEGAL;
            end
            S_MEM_ADDR: w_next_state = (opcode == LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next_state = S_MEM_WB;
            S_MEM_WB:   w_next_state = S_FETCH;
            S_MEM_WR:   if (mem_ready) w_next_state = S_FETCH;
            S_EXEC_R:   w_next_state = S_R_WB;
            S_R_WB:     w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_ILLEGAL:  w_next_state = S_ILLEGAL;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Output decode per state; strobes and the retire pulse are held low during reset
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCSource      = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_REGB;
        ALUOp         = ALUOP_ADD;
        illegal       = 1'b0;
        instr_retired = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_ADDR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite      = 1'b1;
                MemtoReg      = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEM_WR: begin
                IorD          = 1'b1;
                MemWrite      = 1'b1;
                instr_retired = mem_ready;
            end
            S_EXEC_R: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_REGB;
                ALUOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = SRCA_REGA;
                ALUSrcB       = SRCB_REGB;
                ALUOp         = ALUOP_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = 1'b1;
                instr_retired = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            MemWrite      = 1'b0;
            MemRead       = 1'b0;
            instr_retired = 1'b0;
        end
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk     (clk),
        .rst     (reset),
        .i_en    (instr_retired),
        .o_count (retired_count)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (CNT_W = 4 so the counter wrap
// is reachable): table of per-instruction vectors, hand-written corner
// sequences, and randomized instruction streams against a step-list model.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1100111;

    // Instruction steps used by the reference model
    localparam int K_FETCH = 0, K_DECODE = 1, K_MADDR = 2, K_MRD = 3, K_MWB = 4,
                   K_MWR = 5, K_EXR = 6, K_RWB = 7, K_BR = 8;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       pcsrc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rw;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       ill;
        logic       ret;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        int         sf;      // cycles with mem_ready low at start of FETCH
        int         sm;      // low cycles starting at the 4th step
        int         cycles;  // expected instruction length
        int         mrd;     // expected MemRead cycles
        int         mw;      // expected MemWrite cycles
        int         rw;      // expected RegWrite cycles
        int         pcwc;    // expected PCWriteCond cycles
    } vec_t;

    logic             clk;
    logic             reset;
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite;
    logic             IRWrite, MemtoReg, RegWrite;
    logic [1:0]       ALUSrcA, ALUSrcB, ALUOp;
    logic             illegal, instr_retired;
    logic [CNT_W-1:0] retired_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    ctl_t s;
    logic [CNT_W-1:0] s_cnt;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .PCSource      (PCSource),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .illegal       (illegal),
        .instr_retired (instr_retired),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        s.pcw   = PCWrite;   s.pcwc = PCWriteCond; s.pcsrc = PCSource;
        s.iord  = IorD;      s.mrd  = MemRead;     s.mwr   = MemWrite;
        s.irw   = IRWrite;   s.m2r  = MemtoReg;    s.rw    = RegWrite;
        s.srca  = ALUSrcA;   s.srcb = ALUSrcB;     s.aluop = ALUOp;
        s.ill   = illegal;   s.ret  = instr_retired;
        s_cnt   = retired_count;
    endtask

    function automatic logic [5:0] strobes();
        return {PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead};
    endfunction

    // One clock: drive inputs just after the edge, sample mid-cycle
    task automatic cycle(input logic rdy);
        mem_ready = rdy;
        zero      = 1'($urandom_range(0, 1));
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    // Reset while mem_ready is high, so any leaked FETCH strobe would show
    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_strobes", 32'(strobes()), 32'd0);
        check("reset_count", 32'(retired_count), 32'd0);
        check("reset_illegal_ret", {30'd0, illegal, instr_retired}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Expected controls for a given instruction step
    function automatic ctl_t exp_ctl(input int k, input logic rdy);
        ctl_t c;
        c = '0;
        case (k)
            K_FETCH:  begin c.mrd = 1'b1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
            K_DECODE: begin c.srca = 2'b01; c.srcb = 2'b10; end
            K_MADDR:  begin c.srca = 2'b10; c.srcb = 2'b10; end
            K_MRD:    begin c.iord = 1'b1; c.mrd = 1'b1; end
            K_MWB:    begin c.rw = 1'b1; c.m2r = 1'b1; c.ret = 1'b1; end
            K_MWR:    begin c.iord = 1'b1; c.mwr = 1'b1; c.ret = rdy; end
            K_EXR:    begin c.srca = 2'b10; c.aluop = 2'b10; end
            K_RWB:    begin c.rw = 1'b1; c.ret = 1'b1; end
            K_BR:     begin c.srca = 2'b10; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 1'b1; c.ret = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction

    vec_t vecs[9];
    logic [6:0] ops[4];
    int q[$];

    initial begin
        reset     = 1'b1;
        opcode    = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // ---------------- table-driven vectors ----------------
        vecs[0] = '{OP_R,   0, 0, 4, 1, 0, 1, 0};
        vecs[1] = '{OP_LD,  0, 0, 5, 2, 0, 1, 0};
        vecs[2] = '{OP_LD,  0, 3, 8, 5, 0, 1, 0};
        vecs[3] = '{OP_SD,  0, 0, 4, 1, 1, 0, 0};
        vecs[4] = '{OP_SD,  0, 2, 6, 1, 3, 0, 0};
        vecs[5] = '{OP_BEQ, 0, 0, 3, 1, 0, 0, 1};
        vecs[6] = '{OP_BEQ, 1, 0, 4, 2, 0, 0, 1};
        vecs[7] = '{OP_R,   2, 2, 6, 3, 0, 1, 0};
        vecs[8] = '{OP_LD,  1, 1, 7, 4, 0, 1, 0};
        for (int v = 0; v < 9; v++) begin
            int cyc, n_mrd, n_mw, n_rw, n_pcwc;
            logic done, rdy;
            logic [CNT_W-1:0] cnt0;
            cyc = 0; n_mrd = 0; n_mw = 0; n_rw = 0; n_pcwc = 0; done = 1'b0;
            cnt0   = retired_count;
            opcode = vecs[v].op;
            while (!done && cyc < 40) begin
                rdy = !((cyc < vecs[v].sf) ||
                        (cyc >= vecs[v].sf + 3 && cyc < vecs[v].sf + 3 + vecs[v].sm));
                cycle(rdy);
                n_mrd  += int'(s.mrd);
                n_mw   += int'(s.mwr);
                n_rw   += int'(s.rw);
                n_pcwc += int'(s.pcwc);
                cyc++;
                if (s.ret) done = 1'b1;
            end
            check($sformatf("vec%0d_retired", v), 32'(done), 32'd1);
            check($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vecs[v].cycles));
            check($sformatf("vec%0d_memread", v), 32'(n_mrd), 32'(vecs[v].mrd));
            check($sformatf("vec%0d_memwrite", v), 32'(n_mw), 32'(vecs[v].mw));
            check($sformatf("vec%0d_regwrite", v), 32'(n_rw), 32'(vecs[v].rw));
            check($sformatf("vec%0d_pcwcond", v), 32'(n_pcwc), 32'(vecs[v].pcwc));
            check($sformatf("vec%0d_count", v), 32'(retired_count), 32'(CNT_W'(cnt0 + 1'b1)));
        end

        // ---------------- illegal opcode is sticky until reset ----------------
        do_reset();
        opcode = OP_BAD;
        cycle(1'b1);
        check("ill_fetch_flag", 32'(s.ill), 32'd0);
        cycle(1'b1);
        check("ill_decode_ctl", 32'(s), 32'(exp_ctl(K_DECODE, 1'b1)));
        for (int i = 0; i < 20; i++) begin
            opcode = (i % 3 == 0) ? OP_R : OP_BAD;
            cycle(1'(i % 2));
            if (!s.ill || s.ret || s.pcw || s.pcwc || s.irw || s.rw || s.mwr || s.mrd)
                check($sformatf("ill_hold%0d", i), 32'(s), 32'(exp_ctl(-1, 1'b0) | 17'd2));
            else
                n_tests++;
        end
        reset = 1'b1;
        #2;
        check("ill_async_clear", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        opcode = OP_R;
        cycle(1'b1);
        check("ill_back_to_fetch", 32'(s), 32'(exp_ctl(K_FETCH, 1'b1)));

        // ---------------- counter wrap with 16 R-type ----------------
        do_reset();
        opcode = OP_R;
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 4; c++) cycle(1'b1);
            if (i == 14) check("wrap_count15", 32'(retired_count), 32'd15);
        end
        check("wrap_count0", 32'(retired_count), 32'd0);

        // ---------------- reset during MEM_RD aborts the load ----------------
        do_reset();
        opcode = OP_LD;
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);
        check("abort_memrd_ctl", 32'(s), 32'(exp_ctl(K_MRD, 1'b0)));
        mem_ready = 1'b1;
        reset     = 1'b1;
        #2;
        check("abort_strobes", 32'(strobes()), 32'd0);
        check("abort_no_retire", 32'(instr_retired), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b1);
        check("abort_fetch_ctl", 32'(s), 32'(exp_ctl(K_FETCH, 1'b1)));
        check("abort_count", 32'(s_cnt), 32'd0);

        // ---------------- randomized streams vs step-list model ----------------
        do_reset();
        ops[0] = OP_R; ops[1] = OP_LD; ops[2] = OP_SD; ops[3] = OP_BEQ;
        begin
            logic [CNT_W-1:0] model_cnt;
            model_cnt = '0;
            for (int n = 0; n < 40; n++) begin
                int idx, lowcnt, guard;
                logic rdy;
                ctl_t e;
                opcode = ops[$urandom_range(0, 3)];
                q.delete();
                q.push_back(K_FETCH);
                q.push_back(K_DECODE);
                case (opcode)
                    OP_R:    begin q.push_back(K_EXR); q.push_back(K_RWB); end
                    OP_LD:   begin q.push_back(K_MADDR); q.push_back(K_MRD); q.push_back(K_MWB); end
                    OP_SD:   begin q.push_back(K_MADDR); q.push_back(K_MWR); end
                    default: q.push_back(K_BR);
                endcase
                idx = 0; lowcnt = 0; guard = 0;
                while (idx < q.size() && guard < 100) begin
                    rdy = ($urandom_range(0, 3) != 0);
                    if (lowcnt >= 4) rdy = 1'b1;
                    cycle(rdy);
                    e = exp_ctl(q[idx], rdy);
                    check($sformatf("rnd%0d_step%0d_ctl", n, q[idx]), 32'(s), 32'(e));
                    check($sformatf("rnd%0d_count", n), 32'(s_cnt), 32'(model_cnt));
                    if (e.ret) model_cnt = model_cnt + 1'b1;
                    if ((q[idx] == K_FETCH || q[idx] == K_MRD || q[idx] == K_MWR) && !rdy) begin
                        lowcnt++;
                    end else begin
                        idx++;
                        lowcnt = 0;
                    end
                    guard++;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
